// File: rtl/pll_lock_supervisor.sv
// PLL start-up and lock supervisor: pulses the PLL reset, waits for lock with a timeout,
// qualifies lock over a stable window and gates the video-domain reset on it.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYC     = 64,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic       lock_fail,
  output logic [7:0] retry_cnt,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_LOCKED    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       retry_nxt;
  logic             lost_nxt;
  logic             lock_meta, lk;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lk        <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lk        <= lock_meta;
    end
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      cnt         <= '0;
      retry_cnt   <= 8'd0;
      lock_fail   <= 1'b0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      pll_ready   <= 1'b0;
      video_rst_n <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_cnt   <= retry_nxt;
      lock_fail   <= lock_fail | (32'(retry_nxt) >= MAX_RETRY);
      lock_lost   <= lost_nxt;
      pll_rst     <= (state_nxt == S_RESET);
      pll_ready   <= (state_nxt == S_LOCKED);
      video_rst_n <= (state_nxt == S_LOCKED);
    end
  end

  // Next-state logic; the counter clears on every state change so it never wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    case (state)
      S_RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_RESET;
          cnt_nxt   = '0;
          retry_nxt = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_LOCKED;
          cnt_nxt   = '0;
        end
      end
      S_LOCKED: begin
        cnt_nxt = '0;
        if (!lk) begin
          state_nxt = S_RESET;
          lost_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Control-side companion to the video-output PLL. It drives the PLL reset input and consumes the PLL lock output.
- Runs on the PLL reference clock, 50 MHz board oscillator.
- Sequence: pulses PLL reset at start-up, waits for lock with a timeout, then qualifies lock as stable before releasing the video-domain reset.
- Handles lock loss and failed lock attempts by re-resetting the PLL. Exports status to the control/debug logic.

Parameters:
- RST_CYC, 64: cycles pll_rst is held high per reset attempt (≥1).
- TIMEOUT_CYC, 50000: cycles in WAIT_LOCK before an attempt is declared failed (1 ms at 50 MHz).
- STABLE_CYC, 1024: consecutive cycles of synchronized lock=1 needed before ready.
- MAX_RETRY, 8: failed attempts after which sticky lock_fail is raised.
- CNT_W, 20: width of the shared cycle counter. Must hold max(RST_CYC, TIMEOUT_CYC, STABLE_CYC).

Ports:
- clk  in  1  reference clock (same net as PLL clkin1)
- rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  PLL lock output; asynchronous to clk
- pll_rst  out  1  PLL reset, active-high
- video_rst_n  out  1  active-low reset for the video-out domain; 0 unless state LOCKED
- pll_ready  out  1  1 while state LOCKED
- lock_lost  out  1  single-cycle pulse on LOCKED→RESET transition
- lock_fail  out  1  sticky; set when retry_cnt reaches MAX_RETRY
- retry_cnt  out  8  failed attempts since rst_n; saturates at 255
- state_o  out  2  current state encoding, for debug

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous assert, synchronous deassert by the integrating top.
- While rst_n=0:
  - pll_rst=1, video_rst_n=0, pll_ready=0, lock_lost=0, lock_fail=0, retry_cnt=0, counter=0.
  - state=RESET (state_o=2'd0).
- Lock synchronizer: pll_lock passes through a 2-FF synchronizer, reset to 0. Below, "lk" means the synchronized value, 2 cycles of latency.
- States: RESET=0, WAIT_LOCK=1, STABLE=2, LOCKED=3. All outputs are registered.
- RESET:
  - pll_rst=1; counter increments each cycle.
  - When counter == RST_CYC-1, go to WAIT_LOCK and clear counter. pll_rst is therefore high for exactly RST_CYC cycles.
- WAIT_LOCK:
  - pll_rst=0; counter increments.
  - If lk=1, go to STABLE and clear counter.
  - Else if counter == TIMEOUT_CYC-1, go to RESET, clear counter, and increment retry_cnt (saturating at 255).
  - If lk=1 and timeout occur in the same cycle, lk wins.
- STABLE:
  - pll_rst=0; counter increments while lk=1.
  - If lk=0, go back to WAIT_LOCK with counter cleared. The timeout restarts and this is not counted as a retry.
  - When counter == STABLE_CYC-1 with lk=1, go to LOCKED.
- LOCKED:
  - pll_ready=1, video_rst_n=1.
  - If lk=0, go to RESET, clear counter, and pulse lock_lost for 1 cycle. lock_lost is registered and coincides with the first RESET cycle.
  - retry_cnt is not incremented on lock loss.
- Output timing: video_rst_n and pll_ready rise in the cycle after the STABLE→LOCKED decision. Both fall in the same edge that enters RESET from LOCKED.
- lock_fail: set when retry_cnt becomes ≥ MAX_RETRY. It clears only on rst_n. Retrying continues after it is set; the supervisor never gives up.
- Counter: a single CNT_W-bit counter, cleared on every state change, so it can never wrap.
- Mid-operation rst_n assertion: immediately returns to the reset values above, including pll_rst=1, from any state.
- Glitches on pll_lock shorter than 1 clk may be missed by the synchronizer. This is acceptable: lock qualification is done by STABLE_CYC.

Test Plan (sim params RST_CYC=4, TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRY=2):
- Clean lock:
  - Stimulus: release rst_n; pll_lock rises 10 cycles later and stays high.
  - Required: pll_rst high for exactly 4 cycles after release. video_rst_n and pll_ready rise 2 (sync) + 8 (stable) cycles after pll_lock rises, ±1 for registration. retry_cnt=0.
- Timeout/retry:
  - Stimulus: pll_lock held 0.
  - Required: pll_rst pulses of 4 cycles separated by 20 low cycles. retry_cnt reads 1, then 2. lock_fail=1 from the cycle retry_cnt=2 and stays set. Retrying continues.
- Stable-window glitch:
  - Stimulus: lock rises; drop it for 3 cycles after 5 stable cycles; then hold it high.
  - Required: state returns to WAIT_LOCK with no retry increment. Ready is asserted only after a fresh run of 8 consecutive high cycles.
- Lock loss:
  - Stimulus: in LOCKED, drive pll_lock=0.
  - Required: 2 cycles later, lock_lost pulses once. pll_ready=0, video_rst_n=0, pll_rst=1 for 4 cycles. retry_cnt is unchanged. Re-lock recovers normally.
- Async reset mid-STABLE:
  - Stimulus: assert rst_n=0 asynchronously between clock edges.
  - Required: pll_rst=1, state_o=0, retry_cnt=0, lock_fail=0 immediately. After release, the full sequence repeats.
- Simultaneous lk rise and timeout:
  - Stimulus: align the synchronized lock rise with counter=19 in WAIT_LOCK.
  - Required: next state is STABLE and retry_cnt is unchanged.
